// File: rtl/ddp_pkg.sv
// ddp_pkg: shared word layout helpers and frame-state type for the DDP packet loop.
//  Word layout (MSB first): {sop, eop, be[BE_W-1:0], data[DATA_W-1:0]}.
package ddp_pkg;
  localparam int DDP_DATA_W = 256;
  localparam int DDP_BE_W = 7;
  typedef enum logic {IDLE, IN_PKT} frameState_t;
  function automatic int wordW(int dataW, int beW);
    return dataW + beW + 2;
  endfunction
  function automatic int sopBit(int dataW, int beW);
    return dataW + beW + 1;
  endfunction
  function automatic int eopBit(int dataW, int beW);
    return dataW + beW;
  endfunction
  function automatic int beLsb(int dataW);
    return dataW;
  endfunction
endpackage

// File: rtl/ddp_pkt_fifo_mem.sv
// ddp_pkt_fifo_mem: DEPTH x WIDTH flop storage, one synchronous write port, one async read port.
//  clock  : write clock
//  wrEn   : write strobe, wrAddr/wrData : write location and word
//  rdAddr : read location, rdData : combinational read of that location
module ddp_pkt_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (wrEn) mem[wrAddr] <= wrData;
  assign rdData = mem[rdAddr];
endmodule

// File: rtl/ddp_pkt_loop.sv
// ddp_pkt_loop: framed-word loopback FIFO with optional store-and-forward release and error flags.
//  clock/reset                   : core clock, async active-high reset
//  ddpPktDataIn/Push/Full        : write side ({sop,eop,be,data}); push ignored while full
//  ddpPktDataOut/Pop/Empty       : show-ahead read side; data forced to 0 while empty
//  almostFullThreshold/AlmostFull: level comparator
//  fifoLevel/pktCount            : stored words and complete stored packets
//  errClear                      : clears sticky overrun/underrun/framingErr/oversizeErr
module ddp_pkt_loop
  import ddp_pkg::*;
#(
  parameter int DATA_W = DDP_DATA_W,
  parameter int BE_W = DDP_BE_W,
  parameter int DEPTH = 8,
  parameter int STORE_FWD = 0,
  localparam int WORD_W = wordW(DATA_W, BE_W),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] ddpPktDataIn,
  input  logic              ddpPktPush,
  output logic              ddpPktFull,
  output logic [WORD_W-1:0] ddpPktDataOut,
  input  logic              ddpPktPop,
  output logic              ddpPktEmpty,
  input  logic [PTR_W:0]    almostFullThreshold,
  output logic              ddpPktAlmostFull,
  output logic [PTR_W:0]    fifoLevel,
  output logic [PTR_W:0]    pktCount,
  input  logic              errClear,
  output logic              overrun,
  output logic              underrun,
  output logic              framingErr,
  output logic              oversizeErr
);
  localparam int SOP = sopBit(DATA_W, BE_W);
  localparam int EOP = eopBit(DATA_W, BE_W);
  logic [PTR_W:0] wrPtr, rdPtr;
  logic [WORD_W-1:0] headWord;
  logic pushOk, popOk, inSop, inEop, headEop, noPkt, releaseSf, sfStall;
  frameState_t frameState;
  ddp_pkt_fifo_mem #(.WIDTH(WORD_W), .DEPTH(DEPTH)) mem (
    .clock(clock),
    .wrEn(pushOk),
    .wrAddr(wrPtr[PTR_W-1:0]),
    .wrData(ddpPktDataIn),
    .rdAddr(rdPtr[PTR_W-1:0]),
    .rdData(headWord)
  );
  assign inSop = ddpPktDataIn[SOP];
  assign inEop = ddpPktDataIn[EOP];
  assign headEop = headWord[EOP];
  assign fifoLevel = wrPtr - rdPtr;
  assign noPkt = pktCount == '0;
  assign ddpPktFull = (wrPtr[PTR_W] != rdPtr[PTR_W]) && (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
  // In store-and-forward mode a full FIFO holding no complete packet can never drain on its own;
  // releaseSf lets that oversize packet stream out until its eop leaves.
  assign sfStall = (STORE_FWD != 0) && ddpPktFull && noPkt;
  assign ddpPktEmpty = (fifoLevel == '0) || ((STORE_FWD != 0) && noPkt && !releaseSf);
  assign ddpPktDataOut = ddpPktEmpty ? '0 : headWord;
  assign ddpPktAlmostFull = fifoLevel >= almostFullThreshold;
  assign pushOk = ddpPktPush && !ddpPktFull;
  assign popOk = ddpPktPop && !ddpPktEmpty;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      pktCount <= '0;
      releaseSf <= 1'b0;
      frameState <= IDLE;
      overrun <= 1'b0;
      underrun <= 1'b0;
      framingErr <= 1'b0;
      oversizeErr <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + (PTR_W+1)'(1);
      if (popOk) rdPtr <= rdPtr + (PTR_W+1)'(1);
      pktCount <= pktCount + (PTR_W+1)'(pushOk && inEop) - (PTR_W+1)'(popOk && headEop);
      releaseSf <= sfStall ? 1'b1 : (popOk && headEop) ? 1'b0 : releaseSf;
      // A stray non-sop word while idle is stored but does not open a packet.
      if (pushOk && (inSop || frameState == IN_PKT)) frameState <= inEop ? IDLE : IN_PKT;
      overrun <= (overrun && !errClear) || (ddpPktPush && ddpPktFull);
      underrun <= (underrun && !errClear) || (ddpPktPop && ddpPktEmpty);
      // Error when sop presence disagrees with being outside a packet.
      framingErr <= (framingErr && !errClear) || (pushOk && (inSop == (frameState == IN_PKT)));
      oversizeErr <= (oversizeErr && !errClear) || sfStall;
    end
endmodule

// File: tb/tb_ddp_pkt_loop.sv
// tb_ddp_pkt_loop: directed stimulus on cut-through and store-and-forward instances, checked against a queue model.
`define CHK(n, a, e) cmpN(n, int'(a), int'(e))
module tb_ddp_pkt_loop;
  localparam int DW = 256, BW = 7, WW = DW + BW + 2;
  logic clock = 0, reset = 0, push = 0, pop = 0, errClear = 0;
  logic [WW-1:0] din = '0;
  logic [3:0] thr = 4'd6;
  int checks = 0, errors = 0;
  always #5 clock = ~clock;
  function automatic logic [WW-1:0] mk(bit s, bit e, int i);
    logic [31:0] d;
    d = 32'hC0DE0000 + i;
    return {s, e, i[6:0], {8{d}}};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : m
    logic [WW-1:0] dOut;
    logic full, empty, af, ov, un, fr, os;
    logic [3:0] lvl, pc;
    ddp_pkt_loop #(.DATA_W(DW), .BE_W(BW), .DEPTH(8), .STORE_FWD(g)) dut (
      .clock(clock), .reset(reset), .ddpPktDataIn(din), .ddpPktPush(push), .ddpPktFull(full),
      .ddpPktDataOut(dOut), .ddpPktPop(pop), .ddpPktEmpty(empty), .almostFullThreshold(thr),
      .ddpPktAlmostFull(af), .fifoLevel(lvl), .pktCount(pc), .errClear(errClear),
      .overrun(ov), .underrun(un), .framingErr(fr), .oversizeErr(os)
    );
    logic [WW-1:0] q[$];
    logic [WW-1:0] xOut = '0;
    bit inPkt = 0, rel = 0, xOv = 0, xUn = 0, xFr = 0, xOs = 0, xEmpty = 1, xFull = 0;
    int xLvl = 0, xPc = 0;
    always @(posedge clock or posedge reset) begin
      bit pushOk, popOk, evOv, evUn, evFr, evOs;
      if (reset) begin
        q.delete();
        inPkt = 0; rel = 0; xOv = 0; xUn = 0; xFr = 0; xOs = 0;
      end else begin
        pushOk = push && !xFull;
        popOk = pop && !xEmpty;
        evOv = push && xFull;
        evUn = pop && xEmpty;
        evFr = pushOk && (din[WW-1] ? inPkt : !inPkt);
        evOs = (g == 1) && xFull && xPc == 0;
        if (evOs) rel = 1;
        else if (popOk && q[0][WW-2]) rel = 0;
        if (pushOk && (din[WW-1] || inPkt)) inPkt = !din[WW-2];
        if (popOk) void'(q.pop_front());
        if (pushOk) q.push_back(din);
        xOv = (xOv && !errClear) || evOv;
        xUn = (xUn && !errClear) || evUn;
        xFr = (xFr && !errClear) || evFr;
        xOs = (xOs && !errClear) || evOs;
      end
      xLvl = q.size();
      xPc = 0;
      foreach (q[i]) if (q[i][WW-2]) xPc++;
      xFull = xLvl == 8;
      xEmpty = xLvl == 0 || ((g == 1) && xPc == 0 && !rel);
      xOut = xEmpty ? '0 : q[0];
    end
  end
  task automatic cmpN(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask
  task automatic cmpW(string nm, logic [WW-1:0] act, logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic cmpAll();
    if (reset) return;
    cmpW("m0.dataOut", m[0].dOut, m[0].xOut);
    `CHK("m0.full", m[0].full, m[0].xFull);
    `CHK("m0.empty", m[0].empty, m[0].xEmpty);
    `CHK("m0.almostFull", m[0].af, m[0].xLvl >= int'(thr));
    `CHK("m0.level", m[0].lvl, m[0].xLvl);
    `CHK("m0.pktCount", m[0].pc, m[0].xPc);
    `CHK("m0.overrun", m[0].ov, m[0].xOv);
    `CHK("m0.underrun", m[0].un, m[0].xUn);
    `CHK("m0.framingErr", m[0].fr, m[0].xFr);
    `CHK("m0.oversizeErr", m[0].os, m[0].xOs);
    cmpW("m1.dataOut", m[1].dOut, m[1].xOut);
    `CHK("m1.full", m[1].full, m[1].xFull);
    `CHK("m1.empty", m[1].empty, m[1].xEmpty);
    `CHK("m1.almostFull", m[1].af, m[1].xLvl >= int'(thr));
    `CHK("m1.level", m[1].lvl, m[1].xLvl);
    `CHK("m1.pktCount", m[1].pc, m[1].xPc);
    `CHK("m1.overrun", m[1].ov, m[1].xOv);
    `CHK("m1.underrun", m[1].un, m[1].xUn);
    `CHK("m1.framingErr", m[1].fr, m[1].xFr);
    `CHK("m1.oversizeErr", m[1].os, m[1].xOs);
  endtask
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
    cmpAll();
  endtask
  task automatic op(bit ps, bit pp, logic [WW-1:0] w);
    push = ps;
    pop = pp;
    din = w;
    cyc();
    push = 0;
    pop = 0;
  endtask
  task automatic doReset();
    @(negedge clock);
    push = 0; pop = 0; errClear = 0; din = '0;
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask
  initial begin
    doReset();
    `CHK("rst m0 empty", m[0].empty, 1);
    `CHK("rst m1 empty", m[1].empty, 1);
    `CHK("rst m0 full", m[0].full, 0);
    `CHK("rst m0 level", m[0].lvl, 0);
    `CHK("rst m0 almostFull", m[0].af, 0);
    cmpW("rst m0 dataOut", m[0].dOut, '0);
    for (int i = 0; i < 8; i++) op(1, 0, mk(1, 1, i));
    op(1, 0, mk(1, 1, 99));
    `CHK("t1 level", m[0].lvl, 8);
    `CHK("t1 full", m[0].full, 1);
    `CHK("t1 overrun", m[0].ov, 1);
    `CHK("t1 almostFull", m[0].af, 1);
    `CHK("t1 pktCount", m[1].pc, 8);
    for (int i = 0; i < 8; i++) begin
      cmpW("t1 pop order", m[0].dOut, mk(1, 1, i));
      op(0, 1, '0);
    end
    `CHK("t1 drained empty", m[0].empty, 1);
    `CHK("t1 drained level", m[0].lvl, 0);
    doReset();
    op(1, 0, mk(1, 0, 0));
    op(1, 0, mk(0, 0, 1));
    op(1, 0, mk(0, 0, 2));
    `CHK("t2 sf empty held", m[1].empty, 1);
    `CHK("t2 sf pktCount", m[1].pc, 0);
    `CHK("t2 ct empty", m[0].empty, 0);
    op(1, 0, mk(0, 1, 3));
    `CHK("t2 sf empty released", m[1].empty, 0);
    `CHK("t2 sf pktCount eop", m[1].pc, 1);
    cmpW("t2 sf head", m[1].dOut, mk(1, 0, 0));
    for (int i = 0; i < 4; i++) op(0, 1, '0);
    `CHK("t2 sf pktCount after", m[1].pc, 0);
    `CHK("t2 sf empty after", m[1].empty, 1);
    doReset();
    op(1, 0, mk(1, 0, 0));
    for (int i = 1; i < 8; i++) op(1, 0, mk(0, 0, i));
    op(0, 0, '0);
    `CHK("t3 oversizeErr", m[1].os, 1);
    `CHK("t3 sf released", m[1].empty, 0);
    `CHK("t3 ct no oversize", m[0].os, 0);
    for (int i = 0; i < 8; i++) op(0, 1, '0);
    op(1, 0, mk(0, 1, 8));
    op(0, 1, '0);
    op(1, 0, mk(1, 0, 9));
    `CHK("t3 release cleared", m[1].empty, 1);
    `CHK("t3 ct sees word", m[0].empty, 0);
    doReset();
    for (int i = 0; i < 4; i++) op(1, 0, mk(1, 1, i));
    for (int k = 0; k < 20; k++) begin
      op(1, 1, mk(1, 1, 4 + k));
      `CHK("t4 level", m[0].lvl, 4);
      cmpW("t4 order", m[1].dOut, mk(1, 1, k + 1));
    end
    `CHK("t4 almostFull", m[0].af, 0);
    doReset();
    op(1, 0, mk(1, 0, 0));
    `CHK("t5 first sop ok", m[0].fr, 0);
    op(1, 0, mk(1, 0, 1));
    `CHK("t5 second sop", m[0].fr, 1);
    op(1, 0, mk(0, 1, 2));
    errClear = 1;
    op(0, 0, '0);
    errClear = 0;
    `CHK("t5 cleared", m[0].fr, 0);
    errClear = 1;
    op(1, 0, mk(0, 0, 3));
    errClear = 0;
    `CHK("t5 set wins", m[0].fr, 1);
    for (int i = 0; i < 4; i++) op(0, 1, '0);
    `CHK("t5 ct no underrun", m[0].un, 0);
    `CHK("t5 sf underrun", m[1].un, 1);
    op(0, 1, '0);
    `CHK("t5 ct underrun", m[0].un, 1);
    doReset();
    op(1, 0, mk(1, 1, 0));
    op(1, 0, mk(1, 0, 1));
    op(1, 0, mk(0, 0, 2));
    op(1, 0, mk(0, 1, 3));
    op(1, 0, mk(1, 0, 4));
    `CHK("t6 level", m[0].lvl, 5);
    `CHK("t6 pktCount", m[1].pc, 2);
    #2 reset = 1;
    #1;
    `CHK("t6 async level", m[0].lvl, 0);
    `CHK("t6 async pktCount", m[1].pc, 0);
    `CHK("t6 async empty", m[0].empty, 1);
    cmpW("t6 async dataOut", m[0].dOut, '0);
    @(negedge clock);
    reset = 0;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
